reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_pkg.sv | 18 +
 rtl/reg_write_arbiter_if.sv | 28 ++
 rtl/reg_write_arbiter_dffe.sv | 18 +
 rtl/reg_write_arbiter_pick.sv | 32 +++
 rtl/reg_write_arbiter.sv | 100 ++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants for the register write arbiter: defaults, FSM encodings, pointer sizing.
// Purely declarative; no logic, so no latency or backpressure of its own.
package reg_write_arbiter_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ACK  = 2'b10
    } state_t;

    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bundle: per-requester req/wdata plus flush in, stored word and status out.
// Wires only; req is held by each requester until its own ack pulse.
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ
);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic                   flush;
    logic [WIDTH-1:0]       q;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       ack;
    logic                   busy;

    modport master (
        output req, wdata, flush,
        input  q, grant, ack, busy
    );

    modport slave (
        input  req, wdata, flush,
        output q, grant, ack, busy
    );

endinterface

// File: rtl/reg_write_arbiter_dffe.sv
// Single storage bit with synchronous clear and load enable; clear dominates enable.
// One edge from d to q; no backpressure.
module dffe_ref (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (clr)
            q <= 1'b0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/reg_write_arbiter_pick.sv
// Round-robin pick: first set req bit at or above ptr, wrapping; one-hot winner plus index.
// Purely combinational; found is low when no request is pending.
module rr_priority_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int PW    = ptr_bits(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] winner,
    output logic [PW-1:0]    idx,
    output logic             found
);

    always_comb begin
        int c;
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        c      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            c = (int'(ptr) + k) % N_REQ;
            if (!found && req[c]) begin
                found     = 1'b1;
                winner[c] = 1'b1;
                idx       = PW'(c);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter writing one requester's word into a shared register: IDLE -> LOAD -> ACK.
// q updates 2 edges after req is sampled in IDLE, ack the cycle after; requesters wait holding req.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic              clk,
    input  logic              clr,
    reg_write_arbiter_if.slave bus
);

    localparam int PW = ptr_bits(N_REQ);

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [PW-1:0]    owner, owner_nxt;
    logic [N_REQ-1:0] owner_oh, owner_oh_nxt;

    logic [N_REQ-1:0] pick_oh;
    logic [PW-1:0]    pick_idx;
    logic             pick_found;

    logic             load_en;
    logic             word_clr;
    logic [WIDTH-1:0] load_dat;
    logic [WIDTH-1:0] q_word;

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            owner_oh <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            owner_oh <= owner_oh_nxt;
        end
    end

    // Owner is frozen outside IDLE, so req changes during LOAD/ACK cannot steal the slot.
    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        owner_oh_nxt = owner_oh;
        load_en      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nxt    = pick_idx;
                    owner_oh_nxt = pick_oh;
                    state_nxt    = LOAD;
                end
            end
            LOAD: begin
                load_en   = 1'b1;
                ptr_nxt   = (int'(owner) == N_REQ - 1) ? '0 : owner + PW'(1);
                state_nxt = ACK;
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign load_dat = bus.wdata[int'(owner)*WIDTH +: WIDTH];
    assign word_clr = clr | bus.flush;

    // Flush shares the bit-level clear, so a flush during LOAD discards the write.
    for (genvar b = 0; b < WIDTH; b++) begin : g_word
        dffe_ref u_bit (
            .clk (clk),
            .clr (word_clr),
            .en  (load_en),
            .d   (load_dat[b]),
            .q   (q_word[b])
        );
    end

    assign bus.q     = q_word;
    assign bus.grant = (state == LOAD || state == ACK) ? owner_oh : '0;
    assign bus.ack   = (state == ACK) ? owner_oh : '0;
    assign bus.busy  = (state != IDLE);

endmodule
